// File: rtl/semafor_pkg.sv
// Shared definitions for the intersection phase scheduler: phase codes,
// requester indices and the lamp decode used by the output register.
package semafor_pkg;

   typedef enum logic [2:0] {
      ROSU_TOTAL = 3'd0,
      VERDE_NS   = 3'd1,
      GALBEN_NS  = 3'd2,
      VERDE_EV   = 3'd3,
      GALBEN_EV  = 3'd4,
      PIETONI    = 3'd5,
      SERVICE    = 3'd6
   } faza_t;

   localparam logic [1:0] NS  = 2'd0;
   localparam logic [1:0] EV  = 2'd1;
   localparam logic [1:0] PIE = 2'd2;

   typedef struct packed {
      logic rosu_ns;
      logic galben_ns;
      logic verde_ns;
      logic rosu_ev;
      logic galben_ev;
      logic verde_ev;
      logic rosu_pietoni;
      logic verde_pietoni;
   } lampi_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // In SERVICE only the two yellows are lit, following the flash phase.
   function automatic lampi_t decodare(input faza_t f, input logic clipire);
      lampi_t l;
      l = '0;
      if (f == SERVICE) begin
         l.galben_ns = clipire;
         l.galben_ev = clipire;
      end else begin
         l.verde_ns      = (f == VERDE_NS);
         l.galben_ns     = (f == GALBEN_NS);
         l.rosu_ns       = !((f == VERDE_NS) || (f == GALBEN_NS));
         l.verde_ev      = (f == VERDE_EV);
         l.galben_ev     = (f == GALBEN_EV);
         l.rosu_ev       = !((f == VERDE_EV) || (f == GALBEN_EV));
         l.verde_pietoni = (f == PIETONI);
         l.rosu_pietoni  = (f != PIETONI);
      end
      return l;
   endfunction

endpackage

// File: rtl/arbitru_rr.sv
// Three-way round-robin picker: grants the first pending requester after the
// pointer in NS -> EV -> PIE -> NS order. Purely combinational.
module arbitru_rr
   import semafor_pkg::*;
(
   input  logic [2:0] pending,
   input  logic [1:0] ptr,
   output logic [2:0] grant,
   output logic       any
);

   logic [1:0] idx;

   // Walk from lowest to highest priority so the closest requester wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int k = 3; k >= 1; k--) begin
         idx = 2'((int'(ptr) + k) % 3);
         if (pending[idx]) grant = 3'b001 << idx;
      end
   end

   assign any = |pending;

endmodule

// File: rtl/planificator_faze.sv
// Phase scheduler for a four-arm intersection with pedestrian crossing:
// demand latches, round-robin grant, green/yellow/clearance timing, service flash.
module planificator_faze
   import semafor_pkg::*;
#(
   parameter int T_VERDE_MIN = 4,
   parameter int T_VERDE_MAX = 10,
   parameter int T_GALBEN    = 2,
   parameter int T_ROSU      = 1,
   parameter int T_PIETONI   = 5,
   parameter int T_CLIPIRE   = 3
)(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       enable_i,
   input  logic       service_i,
   input  logic       prezenta_ns_i,
   input  logic       prezenta_ev_i,
   input  logic       buton_pietoni_i,
   output logic [2:0] faza_o,
   output logic       rosu_ns_o,
   output logic       galben_ns_o,
   output logic       verde_ns_o,
   output logic       rosu_ev_o,
   output logic       galben_ev_o,
   output logic       verde_ev_o,
   output logic       rosu_pietoni_o,
   output logic       verde_pietoni_o,
   output logic [2:0] cerere_pend_o
);

   localparam int T_MAX = max2(max2(max2(T_VERDE_MIN, T_VERDE_MAX), max2(T_GALBEN, T_ROSU)),
                               max2(T_PIETONI, T_CLIPIRE));
   localparam int CW = $clog2(T_MAX) + 1;

   localparam logic [CW-1:0] C_MIN  = CW'(T_VERDE_MIN - 1);
   localparam logic [CW-1:0] C_MAX  = CW'(T_VERDE_MAX - 1);
   localparam logic [CW-1:0] C_GAL  = CW'(T_GALBEN - 1);
   localparam logic [CW-1:0] C_ROSU = CW'(T_ROSU - 1);
   localparam logic [CW-1:0] C_PIE  = CW'(T_PIETONI - 1);
   localparam logic [CW-1:0] C_CLIP = CW'(T_CLIPIRE - 1);
   localparam logic [CW-1:0] C_SAT  = '1;

   faza_t         faza, faza_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    pend, pend_nxt;
   logic [1:0]    ptr, ptr_nxt;
   logic          clipire, clipire_nxt;
   lampi_t        lampi, lampi_nxt;
   logic [2:0]    grant;
   logic          any;
   logic          alte_ns, alte_ev;

   arbitru_rr u_arbitru (
      .pending (pend),
      .ptr     (ptr),
      .grant   (grant),
      .any     (any)
   );

   assign alte_ns = pend[EV] | pend[PIE];
   assign alte_ev = pend[NS] | pend[PIE];

   always_comb begin
      faza_nxt = faza;
      ptr_nxt  = ptr;
      case (faza)
         ROSU_TOTAL:
            if (cnt == C_ROSU) begin
               if (service_i) begin
                  faza_nxt = SERVICE;
               end else if (!any || grant[NS]) begin
                  faza_nxt = VERDE_NS;
                  ptr_nxt  = NS;
               end else if (grant[EV]) begin
                  faza_nxt = VERDE_EV;
                  ptr_nxt  = EV;
               end else begin
                  faza_nxt = PIETONI;
                  ptr_nxt  = PIE;
               end
            end
         VERDE_NS:
            if (service_i || (alte_ns && ((cnt >= C_MIN && !prezenta_ns_i) || cnt >= C_MAX)))
               faza_nxt = GALBEN_NS;
         GALBEN_NS:
            if (cnt == C_GAL) faza_nxt = ROSU_TOTAL;
         VERDE_EV:
            if (service_i || (alte_ev && ((cnt >= C_MIN && !prezenta_ev_i) || cnt >= C_MAX)))
               faza_nxt = GALBEN_EV;
         GALBEN_EV:
            if (cnt == C_GAL) faza_nxt = ROSU_TOTAL;
         PIETONI:
            if (service_i || cnt == C_PIE) faza_nxt = ROSU_TOTAL;
         SERVICE:
            if (!service_i) begin
               faza_nxt = ROSU_TOTAL;
               ptr_nxt  = PIE;
            end
         default:
            faza_nxt = ROSU_TOTAL;
      endcase
   end

   // Counter saturates so an indefinitely resting green never wraps.
   always_comb begin
      cnt_nxt     = cnt;
      clipire_nxt = clipire;
      if (faza_nxt != faza) begin
         cnt_nxt = '0;
         if (faza_nxt == SERVICE) clipire_nxt = 1'b1;
      end else if (faza == SERVICE && cnt == C_CLIP) begin
         cnt_nxt     = '0;
         clipire_nxt = ~clipire;
      end else if (cnt != C_SAT) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   // Clearing on green entry is applied last so a same-cycle request is dropped.
   always_comb begin
      pend_nxt = pend;
      if (prezenta_ns_i && faza != VERDE_NS)  pend_nxt[NS]  = 1'b1;
      if (prezenta_ev_i && faza != VERDE_EV)  pend_nxt[EV]  = 1'b1;
      if (buton_pietoni_i && faza != PIETONI) pend_nxt[PIE] = 1'b1;
      if (faza_nxt != faza) begin
         case (faza_nxt)
            VERDE_NS: pend_nxt[NS]  = 1'b0;
            VERDE_EV: pend_nxt[EV]  = 1'b0;
            PIETONI:  pend_nxt[PIE] = 1'b0;
            default:  ;
         endcase
      end
      if (faza_nxt == SERVICE) pend_nxt = '0;
   end

   assign lampi_nxt = decodare(faza_nxt, clipire_nxt);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         faza    <= ROSU_TOTAL;
         cnt     <= '0;
         pend    <= '0;
         ptr     <= PIE;
         clipire <= 1'b0;
         lampi   <= decodare(ROSU_TOTAL, 1'b0);
      end else if (enable_i) begin
         faza    <= faza_nxt;
         cnt     <= cnt_nxt;
         pend    <= pend_nxt;
         ptr     <= ptr_nxt;
         clipire <= clipire_nxt;
         lampi   <= lampi_nxt;
      end
   end

   assign faza_o          = faza;
   assign cerere_pend_o   = pend;
   assign rosu_ns_o       = lampi.rosu_ns;
   assign galben_ns_o     = lampi.galben_ns;
   assign verde_ns_o      = lampi.verde_ns;
   assign rosu_ev_o       = lampi.rosu_ev;
   assign galben_ev_o     = lampi.galben_ev;
   assign verde_ev_o      = lampi.verde_ev;
   assign rosu_pietoni_o  = lampi.rosu_pietoni;
   assign verde_pietoni_o = lampi.verde_pietoni;

endmodule

// File: tb/tb_planificator_faze.sv
// Self-checking bench for planificator_faze: per-cycle stimulus/expectation
// records walked in order, expected state queued and popped after each edge.
module tb_planificator_faze;

   logic       clk_i = 1'b0;
   logic       reset_i, enable_i, service_i;
   logic       prezenta_ns_i, prezenta_ev_i, buton_pietoni_i;
   logic [2:0] faza_o, cerere_pend_o;
   logic       rosu_ns_o, galben_ns_o, verde_ns_o;
   logic       rosu_ev_o, galben_ev_o, verde_ev_o;
   logic       rosu_pietoni_o, verde_pietoni_o;

   planificator_faze dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .enable_i        (enable_i),
      .service_i       (service_i),
      .prezenta_ns_i   (prezenta_ns_i),
      .prezenta_ev_i   (prezenta_ev_i),
      .buton_pietoni_i (buton_pietoni_i),
      .faza_o          (faza_o),
      .rosu_ns_o       (rosu_ns_o),
      .galben_ns_o     (galben_ns_o),
      .verde_ns_o      (verde_ns_o),
      .rosu_ev_o       (rosu_ev_o),
      .galben_ev_o     (galben_ev_o),
      .verde_ev_o      (verde_ev_o),
      .rosu_pietoni_o  (rosu_pietoni_o),
      .verde_pietoni_o (verde_pietoni_o),
      .cerere_pend_o   (cerere_pend_o)
   );

   always #5 clk_i = ~clk_i;

   // Input bits {reset, enable, service, prez_ns, prez_ev, button}.
   localparam logic [5:0] RST = 6'b100000;
   localparam logic [5:0] EN  = 6'b010000;
   localparam logic [5:0] SVC = 6'b001000;
   localparam logic [5:0] PNS = 6'b000100;
   localparam logic [5:0] PEV = 6'b000010;
   localparam logic [5:0] BTN = 6'b000001;

   typedef struct packed {
      logic [5:0] in;
      logic [2:0] faza;
      logic [2:0] pend;
      logic       clip;
   } vec_t;

   typedef struct packed {
      logic [2:0] faza;
      logic [2:0] pend;
      logic [7:0] lampi;
   } exp_t;

   vec_t tab[$];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_step  = 0;

   // Lamps {rosu_ns, galben_ns, verde_ns, rosu_ev, galben_ev, verde_ev, rosu_p, verde_p}.
   function automatic logic [7:0] lampi_ref(input logic [2:0] f, input logic c);
      case (f)
         3'd0:    return 8'b1001_0010;
         3'd1:    return 8'b0011_0010;
         3'd2:    return 8'b0101_0010;
         3'd3:    return 8'b1000_0110;
         3'd4:    return 8'b1000_1010;
         3'd5:    return 8'b1001_0001;
         3'd6:    return {1'b0, c, 1'b0, 1'b0, c, 1'b0, 1'b0, 1'b0};
         default: return 8'hxx;
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %b expected %b", name, n_step, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      exp_t e;
      {reset_i, enable_i, service_i, prezenta_ns_i, prezenta_ev_i, buton_pietoni_i} = v.in;
      sb.push_back('{faza: v.faza, pend: v.pend, lampi: lampi_ref(v.faza, v.clip)});
      @(posedge clk_i);
      #1;
      n_step++;
      e = sb.pop_front();
      check("faza", {5'b0, faza_o}, {5'b0, e.faza});
      check("pend", {5'b0, cerere_pend_o}, {5'b0, e.pend});
      check("lampi", {rosu_ns_o, galben_ns_o, verde_ns_o, rosu_ev_o, galben_ev_o, verde_ev_o,
                      rosu_pietoni_o, verde_pietoni_o}, e.lampi);
   endtask

   task automatic run(input logic [5:0] in, input int f, input int p, input logic c);
      step('{in: in, faza: 3'(f), pend: 3'(p), clip: c});
   endtask

   task automatic add(input logic [5:0] in, input int f, input int p, input logic c, input int rep);
      for (int i = 0; i < rep; i++) tab.push_back('{in: in, faza: 3'(f), pend: 3'(p), clip: c});
   endtask

   initial begin
      {reset_i, enable_i, service_i, prezenta_ns_i, prezenta_ev_i, buton_pietoni_i} = RST;

      // Idle: one clearance cycle, then NS green rests with no demand.
      run(RST | EN, 0, 0, 1'b0);
      run(EN, 1, 0, 1'b0);
      for (int i = 0; i < 30; i++) run(EN, 1, 0, 1'b0);

      // Gap-out NS -> EV.
      add(RST | EN, 0, 0, 1'b0, 1);
      add(EN,       1, 0, 1'b0, 1);
      add(EN | PEV, 1, 2, 1'b0, 1);
      add(EN,       1, 2, 1'b0, 2);
      add(EN,       2, 2, 1'b0, 2);
      add(EN,       0, 2, 1'b0, 1);
      add(EN,       3, 0, 1'b0, 1);
      // Round-robin: NS and PIE pending while EV green; PIE is next.
      add(EN | PNS | BTN, 3, 5, 1'b0, 1);
      add(EN,       3, 5, 1'b0, 2);
      add(EN,       4, 5, 1'b0, 2);
      add(EN,       0, 5, 1'b0, 1);
      add(EN,       5, 1, 1'b0, 5);
      add(EN,       0, 1, 1'b0, 1);
      add(EN,       1, 0, 1'b0, 1);
      // Max-out with NS presence held.
      add(EN | PNS | PEV, 1, 2, 1'b0, 1);
      add(EN | PNS, 1, 2, 1'b0, 8);
      add(EN | PNS, 2, 2, 1'b0, 1);
      add(EN,       2, 2, 1'b0, 1);
      add(EN,       0, 2, 1'b0, 1);
      add(EN,       3, 0, 1'b0, 1);
      // Service from EV green.
      add(EN | SVC, 4, 0, 1'b0, 2);
      add(EN | SVC, 0, 0, 1'b0, 1);
      add(EN | SVC, 6, 0, 1'b1, 1);
      add(EN | SVC | PNS | BTN, 6, 0, 1'b1, 1);
      add(EN | SVC, 6, 0, 1'b1, 1);
      add(EN | SVC, 6, 0, 1'b0, 3);
      add(EN | SVC, 6, 0, 1'b1, 1);
      add(EN,       0, 0, 1'b0, 1);
      add(EN,       1, 0, 1'b0, 1);
      // Freeze mid-yellow for 7 cycles.
      add(EN | PEV, 1, 2, 1'b0, 1);
      add(EN,       1, 2, 1'b0, 2);
      add(EN,       2, 2, 1'b0, 1);
      add(PNS | BTN, 2, 2, 1'b0, 7);
      add(EN,       2, 2, 1'b0, 1);
      add(EN,       0, 2, 1'b0, 1);
      add(EN,       3, 0, 1'b0, 1);
      // Reset in the middle of the pedestrian phase.
      add(EN | BTN, 3, 4, 1'b0, 1);
      add(EN,       3, 4, 1'b0, 2);
      add(EN,       4, 4, 1'b0, 2);
      add(EN,       0, 4, 1'b0, 1);
      add(EN,       5, 0, 1'b0, 1);
      add(EN | BTN, 5, 0, 1'b0, 1);
      add(RST,      0, 0, 1'b0, 1);
      add(EN,       1, 0, 1'b0, 1);

      foreach (tab[i]) step(tab[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
